// File: rtl/rs_issue_queue_pkg.sv
// Shared sizes and the entry record for the reservation-station issue queue.
package rs_issue_queue_pkg;

    localparam int RS_SIZE   = 16;
    localparam int TAG_W     = 6;
    localparam int PAYLOAD_W = 32;

    // One reservation-station slot; the valid bit lives in a separate vector.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]     src1_tag;
        logic                 src1_rdy;
        logic [TAG_W-1:0]     src2_tag;
        logic                 src2_rdy;
        logic [TAG_W-1:0]     dst_tag;
    } rs_entry_t;

    // True when a valid broadcast carries the tag a source is waiting on.
    function automatic logic tag_hit(input logic v, input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
        return v && (a == b);
    endfunction

endpackage

// File: rtl/rs_issue_queue_if.sv
// Bundle of dispatch, CDB, selector and issue signals around the issue queue.
//
// Handshake rules:
//   - dispatch: a uop is taken on a rising edge where dispatch_valid=1 and
//     rs_full=0; dispatch_valid while rs_full=1 is dropped.
//   - cdb: cdb_valid/cdb_tag is a broadcast with no back-pressure.
//   - select: sel_req is a request vector; sel_gnt must be one-hot or zero and
//     only bits that are also set in sel_req take effect.
//   - issue: issue_valid is a single-cycle pulse, no ready from the FU.
interface rs_issue_queue_if;
    import rs_issue_queue_pkg::*;

    logic                 dispatch_valid;
    logic [PAYLOAD_W-1:0] dispatch_payload;
    logic [TAG_W-1:0]     dispatch_src1_tag;
    logic                 dispatch_src1_rdy;
    logic [TAG_W-1:0]     dispatch_src2_tag;
    logic                 dispatch_src2_rdy;
    logic [TAG_W-1:0]     dispatch_dst_tag;
    logic                 rs_full;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [RS_SIZE-1:0]   sel_req;
    logic [RS_SIZE-1:0]   sel_gnt;
    logic                 issue_valid;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [TAG_W-1:0]     issue_dst_tag;

    modport master (
        output dispatch_valid, dispatch_payload, dispatch_src1_tag, dispatch_src1_rdy,
        output dispatch_src2_tag, dispatch_src2_rdy, dispatch_dst_tag,
        output cdb_valid, cdb_tag, sel_gnt,
        input  rs_full, sel_req, issue_valid, issue_payload, issue_dst_tag
    );

    modport slave (
        input  dispatch_valid, dispatch_payload, dispatch_src1_tag, dispatch_src1_rdy,
        input  dispatch_src2_tag, dispatch_src2_rdy, dispatch_dst_tag,
        input  cdb_valid, cdb_tag, sel_gnt,
        output rs_full, sel_req, issue_valid, issue_payload, issue_dst_tag
    );

endinterface

// File: rtl/rs_issue_queue_ps16.sv
// 16-way priority selector: grants the highest-index requesting bit when enabled.
module ps16 (
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt
);

    // Scan upward so the last (highest) requester overwrites earlier ones.
    always_comb begin
        gnt = '0;
        if (en) begin
            for (int i = 0; i < 16; i++) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_issue_queue.sv
// 16-entry reservation station: allocate on dispatch, wake on CDB, issue on grant.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    rs_issue_queue_if.slave  bus
);

    logic [RS_SIZE-1:0]   valid_q, valid_d;
    rs_entry_t            entries_q [RS_SIZE];
    rs_entry_t            entries_d [RS_SIZE];
    logic                 issue_valid_q, issue_valid_d;
    logic [PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;
    logic [TAG_W-1:0]     issue_dst_tag_q, issue_dst_tag_d;

    logic [RS_SIZE-1:0]   free_vec, alloc_gnt, req_vec, eff_gnt;
    logic                 full_w, dispatch_fire;
    rs_entry_t            new_entry, granted_entry;

    // Everything the selector and allocator see comes from registered state only.
    assign free_vec      = ~valid_q;
    assign full_w        = &valid_q;
    assign dispatch_fire = bus.dispatch_valid & ~full_w;
    assign eff_gnt       = bus.sel_gnt & req_vec;

    assign bus.rs_full       = full_w;
    assign bus.sel_req       = req_vec;
    assign bus.issue_valid   = issue_valid_q;
    assign bus.issue_payload = issue_payload_q;
    assign bus.issue_dst_tag = issue_dst_tag_q;

    ps16 u_alloc (
        .en  (1'b1),
        .req (free_vec),
        .gnt (alloc_gnt)
    );

    // Request vector: valid entries whose two sources are both available.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            req_vec[i] = valid_q[i] & entries_q[i].src1_rdy & entries_q[i].src2_rdy;
        end
    end

    // Incoming uop, with a source marked ready if the CDB broadcasts its tag this cycle.
    always_comb begin
        new_entry          = '0;
        new_entry.payload  = bus.dispatch_payload;
        new_entry.src1_tag = bus.dispatch_src1_tag;
        new_entry.src2_tag = bus.dispatch_src2_tag;
        new_entry.dst_tag  = bus.dispatch_dst_tag;
        new_entry.src1_rdy = bus.dispatch_src1_rdy |
                             tag_hit(bus.cdb_valid, bus.dispatch_src1_tag, bus.cdb_tag);
        new_entry.src2_rdy = bus.dispatch_src2_rdy |
                             tag_hit(bus.cdb_valid, bus.dispatch_src2_tag, bus.cdb_tag);
    end

    // One-hot mux of the granted entry toward the issue registers.
    always_comb begin
        granted_entry = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (eff_gnt[i]) granted_entry = entries_q[i];
        end
    end

    // Next entry state: wakeup, issue invalidate and allocation act independently.
    always_comb begin
        valid_d = valid_q & ~eff_gnt;
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = entries_q[i];
            if (valid_q[i] && tag_hit(bus.cdb_valid, entries_q[i].src1_tag, bus.cdb_tag))
                entries_d[i].src1_rdy = 1'b1;
            if (valid_q[i] && tag_hit(bus.cdb_valid, entries_q[i].src2_tag, bus.cdb_tag))
                entries_d[i].src2_rdy = 1'b1;
            // The allocated slot was free in valid_q, so it never collides with an issue.
            if (dispatch_fire && alloc_gnt[i]) begin
                entries_d[i] = new_entry;
                valid_d[i]   = 1'b1;
            end
        end
    end

    // Issue registers load on an effective grant; data holds otherwise.
    always_comb begin
        issue_valid_d   = |eff_gnt;
        issue_payload_d = issue_payload_q;
        issue_dst_tag_d = issue_dst_tag_q;
        if (|eff_gnt) begin
            issue_payload_d = granted_entry.payload;
            issue_dst_tag_d = granted_entry.dst_tag;
        end
    end

    // Entry array and valid vector; reset empties the station immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= entries_d[i];
        end
    end

    // Registered issue port toward the functional unit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_valid_q   <= 1'b0;
            issue_payload_q <= '0;
            issue_dst_tag_q <= '0;
        end else begin
            issue_valid_q   <= issue_valid_d;
            issue_payload_q <= issue_payload_d;
            issue_dst_tag_q <= issue_dst_tag_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: directed scenarios plus a randomized phase, all
// compared against a slot-array reference model of the station.
module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rs_issue_queue_if bus ();

    rs_issue_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one record per slot plus the issue port.
    bit                   m_valid [RS_SIZE];
    bit                   m_r1    [RS_SIZE];
    bit                   m_r2    [RS_SIZE];
    logic [TAG_W-1:0]     m_t1    [RS_SIZE];
    logic [TAG_W-1:0]     m_t2    [RS_SIZE];
    logic [TAG_W-1:0]     m_dst   [RS_SIZE];
    logic [PAYLOAD_W-1:0] m_pay   [RS_SIZE];
    bit                   m_iv;
    logic [PAYLOAD_W-1:0] m_ipay;
    logic [TAG_W-1:0]     m_idst;

    function automatic logic [RS_SIZE-1:0] m_req();
        logic [RS_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < RS_SIZE; i++) r[i] = m_valid[i] && m_r1[i] && m_r2[i];
        return r;
    endfunction

    function automatic bit m_full();
        int c;
        c = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m_valid[i]) c++;
        return c == RS_SIZE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) begin
            m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
            m_t1[i] = '0; m_t2[i] = '0; m_dst[i] = '0; m_pay[i] = '0;
        end
        m_iv = 0; m_ipay = '0; m_idst = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("sel_req", 32'(bus.sel_req), 32'(m_req()));
        chk("rs_full", 32'(bus.rs_full), 32'(m_full()));
        chk("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
        if (m_iv) begin
            chk("issue_payload", bus.issue_payload, m_ipay);
            chk("issue_dst_tag", 32'(bus.issue_dst_tag), 32'(m_idst));
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // then compare at the next falling edge.
    task automatic step(input bit dv, input logic [PAYLOAD_W-1:0] pay,
                        input logic [TAG_W-1:0] t1, input bit r1,
                        input logic [TAG_W-1:0] t2, input bit r2,
                        input logic [TAG_W-1:0] dst,
                        input bit cv, input logic [TAG_W-1:0] ct,
                        input logic [RS_SIZE-1:0] gnt);
        logic [RS_SIZE-1:0] eg;
        int slot;
        bus.dispatch_valid    = dv;
        bus.dispatch_payload  = pay;
        bus.dispatch_src1_tag = t1;
        bus.dispatch_src1_rdy = r1;
        bus.dispatch_src2_tag = t2;
        bus.dispatch_src2_rdy = r2;
        bus.dispatch_dst_tag  = dst;
        bus.cdb_valid         = cv;
        bus.cdb_tag           = ct;
        bus.sel_gnt           = gnt;
        eg   = gnt & m_req();
        slot = -1;
        if (dv && !m_full())
            for (int i = 0; i < RS_SIZE; i++) if (!m_valid[i]) slot = i;
        @(posedge clock);
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m_valid[i] && cv && m_t1[i] == ct) m_r1[i] = 1;
            if (m_valid[i] && cv && m_t2[i] == ct) m_r2[i] = 1;
        end
        m_iv = (eg != '0);
        for (int i = 0; i < RS_SIZE; i++) begin
            if (eg[i]) begin
                m_ipay = m_pay[i];
                m_idst = m_dst[i];
                m_valid[i] = 0;
            end
        end
        if (slot >= 0) begin
            m_valid[slot] = 1;
            m_pay[slot] = pay; m_dst[slot] = dst;
            m_t1[slot] = t1; m_t2[slot] = t2;
            m_r1[slot] = r1 || (cv && t1 == ct);
            m_r2[slot] = r2 || (cv && t2 == ct);
        end
        @(negedge clock);
        check_state();
    endtask

    task automatic idle(input logic [RS_SIZE-1:0] gnt);
        step(0, '0, '0, 0, '0, 0, '0, 0, '0, gnt);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [RS_SIZE-1:0] gnt;
        int                 req_idx[$];
        reset = 1'b1;
        bus.dispatch_valid = 0; bus.dispatch_payload = '0;
        bus.dispatch_src1_tag = '0; bus.dispatch_src1_rdy = 0;
        bus.dispatch_src2_tag = '0; bus.dispatch_src2_rdy = 0;
        bus.dispatch_dst_tag = '0; bus.cdb_valid = 0; bus.cdb_tag = '0; bus.sel_gnt = '0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("rst_rs_full", 32'(bus.rs_full), 32'd0);
        chk("rst_sel_req", 32'(bus.sel_req), 32'd0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_issue_payload", bus.issue_payload, 32'd0);
        chk("rst_issue_dst", 32'(bus.issue_dst_tag), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Ready uop lands in slot 15 and issues one cycle after its grant.
        step(1, 32'hA5A5_0001, 6'd1, 1, 6'd2, 1, 6'd5, 0, '0, '0);
        chk("t1_req", 32'(bus.sel_req), 32'h8000);
        idle(16'h8000);
        chk("t1_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_issue_dst", 32'(bus.issue_dst_tag), 32'd5);
        chk("t1_freed", 32'(bus.sel_req), 32'd0);

        // Wakeup by CDB, then dispatch/CDB bypass.
        step(1, 32'h0000_0707, 6'd7, 0, 6'd1, 1, 6'd10, 0, '0, '0);
        chk("t2_not_ready", 32'(bus.sel_req), 32'd0);
        step(0, '0, '0, 0, '0, 0, '0, 1, 6'd7, '0);
        chk("t2_woken", 32'(bus.sel_req), 32'h8000);
        step(1, 32'h0000_0909, 6'd9, 0, 6'd3, 1, 6'd11, 1, 6'd9, '0);
        chk("t2_bypass", 32'(bus.sel_req), 32'hC000);
        idle(16'h8000);
        chk("t2_issue_dst15", 32'(bus.issue_dst_tag), 32'd10);
        idle(16'h4000);
        chk("t2_issue_dst14", 32'(bus.issue_dst_tag), 32'd11);

        // Fill all 16 slots; slot 8 waits on tag 20.
        for (int k = 0; k < RS_SIZE; k++)
            step(1, 32'h100 + 32'(k), (k == 7) ? 6'd20 : 6'd1, k != 7, 6'd2, 1,
                 TAG_W'(32 + k), 0, '0, '0);
        chk("t3_full", 32'(bus.rs_full), 32'd1);
        chk("t3_req", 32'(bus.sel_req), 32'hFEFF);
        step(1, 32'hDEAD_BEEF, 6'd1, 1, 6'd1, 1, 6'd63, 0, '0, '0);
        chk("t3_17th_ignored", 32'(bus.rs_full), 32'd1);
        // Issue slot 3 and wake slot 8 in the same edge.
        step(0, '0, '0, 0, '0, 0, '0, 1, 6'd20, 16'h0008);
        chk("t4_not_full", 32'(bus.rs_full), 32'd0);
        chk("t4_issue_dst", 32'(bus.issue_dst_tag), 32'd44);
        chk("t4_req", 32'(bus.sel_req), 32'hFFF7);
        step(1, 32'h0000_0333, 6'd1, 1, 6'd1, 1, 6'd50, 0, '0, '0);
        chk("t4_refill_full", 32'(bus.rs_full), 32'd1);
        idle(16'h0008);
        chk("t4_slot3_dst", 32'(bus.issue_dst_tag), 32'd50);
        // Grant on an empty slot is ignored.
        idle(16'h0008);
        chk("t5_nonreq_gnt", 32'(bus.issue_valid), 32'd0);

        // Randomized traffic.
        sync_reset();
        for (int c = 0; c < 400; c++) begin
            gnt = '0;
            case ($urandom_range(0, 3))
                0: gnt = '0;
                1: gnt[$urandom_range(0, RS_SIZE - 1)] = 1'b1;
                default: begin
                    req_idx.delete();
                    for (int i = 0; i < RS_SIZE; i++) if (m_req()[i]) req_idx.push_back(i);
                    if (req_idx.size() > 0)
                        gnt[req_idx[$urandom_range(0, req_idx.size() - 1)]] = 1'b1;
                end
            endcase
            step($urandom_range(0, 3) != 0, $urandom,
                 TAG_W'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                 TAG_W'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                 TAG_W'($urandom_range(0, 63)),
                 $urandom_range(0, 1) == 1, TAG_W'($urandom_range(0, 7)), gnt);
        end

        // Asynchronous reset with 10 entries and an issue in flight.
        sync_reset();
        for (int k = 0; k < 10; k++)
            step(1, $urandom, 6'd1, 1, 6'd2, 1, TAG_W'(k), 0, '0, '0);
        idle(16'h8000);
        chk("t6_issue_pending", 32'(bus.issue_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_async_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("t6_async_sel_req", 32'(bus.sel_req), 32'd0);
        chk("t6_async_rs_full", 32'(bus.rs_full), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        idle('0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
